pc_gen_unit: RTL and testbench

- Parametrised program-counter generator for the RV32/RV64 core.
- Owns the architectural fetch PC register and resolves all six conditional branch types, JAL and JALR. Adds stall hold with a one-entry pending-redirect buffer, optional compressed-instruction stepping, misaligned-target trapping and an external trap redirect.
- Sits between fetch (consumes pc_o) and execute (supplies resolution inputs). Drives the flush to the IF/ID stages.

---
 rtl/pc_pkg.sv | 24 ++
 rtl/branch_cond.sv | 27 ++
 rtl/pc_gen_unit.sv | 121 ++++++++++++
 tb/tb_pc_gen_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter generator.
package pc_pkg;

  localparam int unsigned ILEN_STEP = 4;
  localparam int unsigned CLEN_STEP = 2;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct_e;

  typedef enum logic [2:0] {
    SEQ,
    BR,
    PEND,
    TRAP,
    MISALIGN
  } next_pc_sel_e;

endpackage

// File: rtl/branch_cond.sv
// Decodes branch funct3 against the comparator flags into a taken condition.
module branch_cond
  import pc_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       lt_i,
  input  logic       ltu_i,
  output logic       cond_o,
  output logic       illegal_o
);

  always_comb begin
    cond_o    = 1'b0;
    illegal_o = 1'b0;
    case (br_funct_e'(funct3_i))
      BEQ:     cond_o = zero_i;
      BNE:     cond_o = ~zero_i;
      BLT:     cond_o = lt_i;
      BGE:     cond_o = ~lt_i;
      BLTU:    cond_o = ltu_i;
      BGEU:    cond_o = ~ltu_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/pc_gen_unit.sv
// Fetch PC register with branch/jump resolution, stall-time redirect buffering and
// misaligned-target trapping.
module pc_gen_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
  parameter bit              C_EXT        = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            ex_valid_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic            branch_i,
  input  logic            jump_i,
  input  logic            jal_i,
  input  logic [2:0]      funct3_i,
  input  logic            zero_i,
  input  logic            lt_i,
  input  logic            ltu_i,
  input  logic [XLEN-1:0] imm_pc_i,
  input  logic [XLEN-1:0] jalr_tgt_i,
  input  logic            is_c_i,
  input  logic            trap_req_i,
  input  logic [XLEN-1:0] trap_vec_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_seq_o,
  output logic            taken_o,
  output logic            flush_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] epc_o,
  output logic            illegal_br_o
);

  logic [XLEN-1:0] r_pc;
  logic            r_pend_vld;
  logic [XLEN-1:0] r_pend_tgt;
  logic            r_misalign;
  logic [XLEN-1:0] r_epc;

  logic            w_cond;
  logic            w_illegal;
  logic            w_taken;
  logic            w_misalign;
  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_step;
  logic [XLEN-1:0] w_pc_seq;
  logic [XLEN-1:0] w_pc_next;
  next_pc_sel_e    w_sel;

  branch_cond u_branch_cond (
    .funct3_i  (funct3_i),
    .zero_i    (zero_i),
    .lt_i      (lt_i),
    .ltu_i     (ltu_i),
    .cond_o    (w_cond),
    .illegal_o (w_illegal)
  );

  always_comb begin
    w_taken  = ex_valid_i & (jump_i | (branch_i & w_cond));
    w_target = (jump_i & ~jal_i) ? {jalr_tgt_i[XLEN-1:1], 1'b0} : ex_pc_i + imm_pc_i;
    // With compressed support, 2-byte aligned targets are legal.
    w_misalign = w_taken & w_target[1] & ~C_EXT;
    w_step   = (C_EXT && is_c_i) ? XLEN'(CLEN_STEP) : XLEN'(ILEN_STEP);
    w_pc_seq = r_pc + w_step;
  end

  always_comb begin
    w_sel = SEQ;
    if (trap_req_i)      w_sel = TRAP;
    else if (w_misalign) w_sel = MISALIGN;
    else if (w_taken)    w_sel = BR;
    else if (r_pend_vld) w_sel = PEND;

    w_pc_next  = w_pc_seq;
    w_redirect = 1'b0;
    unique case (w_sel)
      TRAP:     begin w_pc_next = trap_vec_i;  w_redirect = 1'b1; end
      MISALIGN: begin w_pc_next = TRAP_VECTOR; w_redirect = 1'b1; end
      BR:       begin w_pc_next = w_target;    w_redirect = 1'b1; end
      PEND:     w_pc_next = r_pend_tgt;
      default:  w_pc_next = w_pc_seq;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pc       <= RESET_VECTOR;
      r_pend_vld <= 1'b0;
      r_pend_tgt <= '0;
      r_misalign <= 1'b0;
      r_epc      <= '0;
    end else begin
      r_misalign <= w_misalign;
      if (w_misalign) r_epc <= ex_pc_i;
      if (stall_i) begin
        // Latest redirect seen during a stall wins; replayed when fetch resumes.
        if (w_redirect) begin
          r_pend_vld <= 1'b1;
          r_pend_tgt <= w_pc_next;
        end
      end else begin
        r_pc       <= w_pc_next;
        r_pend_vld <= 1'b0;
      end
    end
  end

  assign pc_o         = r_pc;
  assign pc_seq_o     = w_pc_seq;
  assign taken_o      = w_taken;
  assign flush_o      = w_taken | trap_req_i | w_misalign;
  assign misalign_o   = r_misalign;
  assign epc_o        = r_epc;
  assign illegal_br_o = branch_i & w_illegal;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Directed bench: one instance without and one with compressed support.
module tb_pc_gen_unit;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            stall_i, ex_valid_i, branch_i, jump_i, jal_i;
  logic [XLEN-1:0] ex_pc_i, imm_pc_i, jalr_tgt_i, trap_vec_i;
  logic [2:0]      funct3_i;
  logic            zero_i, lt_i, ltu_i, is_c_i, trap_req_i;

  logic [XLEN-1:0] pc, pc_seq, epc;
  logic            taken, flush, misalign, illegal;
  logic [XLEN-1:0] c_pc, c_pc_seq, c_epc;
  logic            c_taken, c_flush, c_misalign, c_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_gen_unit #(
    .XLEN(XLEN), .RESET_VECTOR(32'h1000), .TRAP_VECTOR(32'h100), .C_EXT(1'b0)
  ) u_dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i),
    .branch_i(branch_i), .jump_i(jump_i), .jal_i(jal_i), .funct3_i(funct3_i),
    .zero_i(zero_i), .lt_i(lt_i), .ltu_i(ltu_i), .imm_pc_i(imm_pc_i),
    .jalr_tgt_i(jalr_tgt_i), .is_c_i(is_c_i), .trap_req_i(trap_req_i),
    .trap_vec_i(trap_vec_i), .pc_o(pc), .pc_seq_o(pc_seq), .taken_o(taken),
    .flush_o(flush), .misalign_o(misalign), .epc_o(epc), .illegal_br_o(illegal)
  );

  pc_gen_unit #(
    .XLEN(XLEN), .RESET_VECTOR(32'h10), .TRAP_VECTOR(32'h100), .C_EXT(1'b1)
  ) u_dut_c (
    .clk(clk), .reset(reset), .stall_i(stall_i), .ex_valid_i(ex_valid_i), .ex_pc_i(ex_pc_i),
    .branch_i(branch_i), .jump_i(jump_i), .jal_i(jal_i), .funct3_i(funct3_i),
    .zero_i(zero_i), .lt_i(lt_i), .ltu_i(ltu_i), .imm_pc_i(imm_pc_i),
    .jalr_tgt_i(jalr_tgt_i), .is_c_i(is_c_i), .trap_req_i(trap_req_i),
    .trap_vec_i(trap_vec_i), .pc_o(c_pc), .pc_seq_o(c_pc_seq), .taken_o(c_taken),
    .flush_o(c_flush), .misalign_o(c_misalign), .epc_o(c_epc), .illegal_br_o(c_illegal)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i    = 1'b0; ex_valid_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0; jal_i = 1'b0;
    funct3_i   = 3'b000; zero_i = 1'b0; lt_i = 1'b0; ltu_i = 1'b0; is_c_i = 1'b0;
    trap_req_i = 1'b0; ex_pc_i = '0; imm_pc_i = '0; jalr_tgt_i = '0; trap_vec_i = '0;
  endtask

  task automatic set_jal(input logic [XLEN-1:0] epc_v, input logic [XLEN-1:0] imm);
    ex_valid_i = 1'b1; jump_i = 1'b1; jal_i = 1'b1; branch_i = 1'b0;
    ex_pc_i = epc_v; imm_pc_i = imm;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    check_val("reset_pc", pc, 32'h1000);
    check_val("reset_misalign", misalign, 0);
    check_val("reset_epc", epc, 0);
    check_val("reset_pc_c", c_pc, 32'h10);

    // Sequential stepping after reset release.
    reset = 1'b1;
    #1 check_val("seq_pc0", pc, 32'h1000);
    tick(); check_val("seq_pc1", pc, 32'h1004);
    tick(); check_val("seq_pc2", pc, 32'h1008);
    tick(); check_val("seq_pc3", pc, 32'h100C);
    check_val("seq_pc_seq", pc_seq, 32'h1010);

    // BLTU backwards, taken.
    ex_valid_i = 1'b1; branch_i = 1'b1; funct3_i = 3'b110;
    ex_pc_i = 32'h2000; imm_pc_i = 32'hFFFF_FFF8; ltu_i = 1'b1; lt_i = 1'b0;
    #1;
    check_val("bltu_taken", taken, 1);
    check_val("bltu_flush", flush, 1);
    check_val("bltu_illegal", illegal, 0);
    tick(); check_val("bltu_pc", pc, 32'h1FF8);

    // Same flags as BLT: not taken.
    funct3_i = 3'b100;
    #1;
    check_val("blt_taken", taken, 0);
    check_val("blt_flush", flush, 0);
    tick(); check_val("blt_pc", pc, 32'h1FFC);

    // Reserved funct3 flagged illegal and never taken, even with zero set.
    funct3_i = 3'b010; zero_i = 1'b1;
    #1;
    check_val("illegal_flag", illegal, 1);
    check_val("illegal_taken", taken, 0);
    tick(); check_val("illegal_pc", pc, 32'h2000);

    // JALR to 'h3003 -> 'h3002, misaligned without C.
    idle_inputs();
    ex_valid_i = 1'b1; jump_i = 1'b1; jal_i = 1'b0; jalr_tgt_i = 32'h3003; ex_pc_i = 32'h2100;
    #1;
    check_val("jalr_taken", taken, 1);
    check_val("jalr_flush", flush, 1);
    tick();
    check_val("mis_pc", pc, 32'h100);
    check_val("mis_pulse", misalign, 1);
    check_val("mis_epc", epc, 32'h2100);
    check_val("mis_c_pc", c_pc, 32'h3002);
    check_val("mis_c_nopulse", c_misalign, 0);
    idle_inputs();
    tick();
    check_val("mis_pulse_end", misalign, 0);
    check_val("mis_epc_hold", epc, 32'h2100);
    check_val("mis_pc_next", pc, 32'h104);

    // Stall with two redirects; the later one wins.
    stall_i = 1'b1; set_jal(32'h3000, 32'h1000);
    #1 check_val("stall_flush", flush, 1);
    tick(); check_val("stall_pc1", pc, 32'h104);
    set_jal(32'h3000, 32'h2000);
    tick(); check_val("stall_pc2", pc, 32'h104);
    idle_inputs(); stall_i = 1'b1;
    tick(); check_val("stall_pc3", pc, 32'h104);
    stall_i = 1'b0;
    tick(); check_val("stall_replay", pc, 32'h5000);
    tick(); check_val("stall_cleared", pc, 32'h5004);

    // Compressed stepping, then trap beats a taken branch.
    reset = 1'b0;
    tick();
    check_val("c_reset_pc", c_pc, 32'h10);
    reset = 1'b1; is_c_i = 1'b1;
    #1;
    check_val("c_pc_seq", c_pc_seq, 32'h12);
    check_val("noc_pc_seq", pc_seq, 32'h1004);
    tick(); check_val("c_step", c_pc, 32'h12);
    ex_valid_i = 1'b1; branch_i = 1'b1; funct3_i = 3'b000; zero_i = 1'b1;
    ex_pc_i = 32'h200; imm_pc_i = 32'h40; trap_req_i = 1'b1; trap_vec_i = 32'h80;
    #1 check_val("trap_flush_c", c_flush, 1);
    tick();
    check_val("trap_pc_c", c_pc, 32'h80);
    check_val("trap_pc", pc, 32'h80);

    // Reset while a redirect is pending: buffer must not be replayed.
    idle_inputs();
    stall_i = 1'b1; set_jal(32'h3000, 32'h1000);
    tick(); check_val("pend_hold", pc, 32'h80);
    idle_inputs(); stall_i = 1'b1; reset = 1'b0;
    tick(); check_val("pend_reset_pc", pc, 32'h1000);
    reset = 1'b1; stall_i = 1'b0;
    tick(); check_val("pend_no_replay", pc, 32'h1004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
